// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer and its halt detector.
package pc_sequencer_pkg;

  // Run-control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Halt cause encodings reported while done is high
  localparam logic [1:0] HALT_NONE  = 2'b00;
  localparam logic [1:0] HALT_LOOP  = 2'b01;
  localparam logic [1:0] HALT_FAULT = 2'b10;
  localparam logic [1:0] HALT_WDOG  = 2'b11;

  // A fetch address is illegal when misaligned or past the end of instruction memory.
  // The comparison is unsigned across the full 32 bits.
  function automatic logic is_fetch_fault(input logic [31:0] addr,
                                          input logic [31:0] im_bytes);
    return (addr[1:0] != 2'b00) || (addr >= im_bytes);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer (slave side) and the CPU / run controller (master side).
interface pc_sequencer_if;
  logic        start;
  logic [31:0] PC_Addr;
  logic [31:0] Next_Addr;
  logic        cpu_en;
  logic        busy;
  logic        done;
  logic [1:0]  halt_cause;
  logic [31:0] retired;

  modport master (
    output start,
    output Next_Addr,
    input  PC_Addr,
    input  cpu_en,
    input  busy,
    input  done,
    input  halt_cause,
    input  retired
  );

  modport slave (
    input  start,
    input  Next_Addr,
    output PC_Addr,
    output cpu_en,
    output busy,
    output done,
    output halt_cause,
    output retired
  );
endinterface

// File: rtl/pc_sequencer_halt_detect.sv
// Combinational, prioritized halt detection: self-loop, then fetch fault, then watchdog.
module pc_halt_detect
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] IM_BYTES  = 32'd1024,
  parameter logic [31:0] MAX_INSTR = 32'd1024
) (
  input  logic [31:0] pc_addr_i,
  input  logic [31:0] next_addr_i,
  input  logic [31:0] retired_i,
  output logic [1:0]  halt_cause_o
);

  // Pick the highest-priority halt condition for the instruction now executing
  always_comb begin
    halt_cause_o = HALT_NONE;
    if (next_addr_i == pc_addr_i) begin
      halt_cause_o = HALT_LOOP;
    end else if (is_fetch_fault(next_addr_i, IM_BYTES)) begin
      halt_cause_o = HALT_FAULT;
    end else if ((retired_i + 32'd1) == MAX_INSTR) begin
      halt_cause_o = HALT_WDOG;
    end else begin
      halt_cause_o = HALT_NONE;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run control: owns the PC, gates CPU writes, counts
// retired instructions and stops on self-loop, fetch fault or watchdog.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] IM_BYTES  = 32'd1024,
  parameter logic [31:0] MAX_INSTR = 32'd1024
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [1:0]  cause_q, cause_d;
  logic [1:0]  halt_s;

  pc_halt_detect #(
    .IM_BYTES  (IM_BYTES),
    .MAX_INSTR (MAX_INSTR)
  ) u_halt_detect (
    .pc_addr_i    (pc_q),
    .next_addr_i  (bus.Next_Addr),
    .retired_i    (retired_q),
    .halt_cause_o (halt_s)
  );

  // State register; reset drops straight to IDLE so cpu_en falls without a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? RUN : IDLE;
      RUN:     state_d = (halt_s != HALT_NONE) ? HALT : RUN;
      HALT:    state_d = bus.start ? RUN : HALT;
      default: state_d = IDLE;
    endcase
  end

  // Run-control outputs decode directly from the state register
  always_comb begin
    bus.cpu_en = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cpu_en = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
      end
      RUN: begin
        bus.cpu_en = 1'b1;
        bus.busy   = 1'b1;
        bus.done   = 1'b0;
      end
      HALT: begin
        bus.cpu_en = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b1;
      end
      default: begin
        bus.cpu_en = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
      end
    endcase
  end

  // Next PC / retired count / halt cause; a halting instruction retires but leaves the PC on itself
  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    case (state_q)
      IDLE: begin
        pc_d      = RESET_PC;
        retired_d = 32'd0;
        cause_d   = HALT_NONE;
      end
      RUN: begin
        retired_d = retired_q + 32'd1;
        if (halt_s != HALT_NONE) begin
          cause_d = halt_s;
        end else begin
          pc_d = bus.Next_Addr;
        end
      end
      HALT: begin
        if (bus.start) begin
          pc_d      = RESET_PC;
          retired_d = 32'd0;
          cause_d   = HALT_NONE;
        end else begin
          pc_d      = pc_q;
          retired_d = retired_q;
          cause_d   = cause_q;
        end
      end
      default: begin
        pc_d      = RESET_PC;
        retired_d = 32'd0;
        cause_d   = HALT_NONE;
      end
    endcase
  end

  // PC, retired count and halt cause registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
      cause_q   <= HALT_NONE;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
    end
  end

  assign bus.PC_Addr    = pc_q;
  assign bus.retired    = retired_q;
  assign bus.halt_cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_sequencer_if bus();
  pc_sequencer_if bus2();

  // Main DUT: reset PC 0, small watchdog so it can be reached quickly
  pc_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .IM_BYTES  (32'd1024),
    .MAX_INSTR (32'd8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Second DUT whose reset PC is already out of range, to exercise loop-vs-fault priority
  pc_sequencer #(
    .RESET_PC  (32'h0000_0800),
    .IM_BYTES  (32'd1024),
    .MAX_INSTR (32'd8)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.Next_Addr = 32'd0;
    bus2.start = 1'b0;
    bus2.Next_Addr = 32'd0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.PC_Addr !== 32'd0) begin errors++; $display("FAIL reset_pc actual=%h required=%h", bus.PC_Addr, 32'd0); end
    checks++; if (bus.retired !== 32'd0) begin errors++; $display("FAIL reset_retired actual=%0d required=0", bus.retired); end
    checks++; if (bus.halt_cause !== 2'b00) begin errors++; $display("FAIL reset_cause actual=%b required=00", bus.halt_cause); end
    checks++; if ({bus.cpu_en, bus.busy, bus.done} !== 3'b000) begin errors++; $display("FAIL reset_ctl actual=%b required=000", {bus.cpu_en, bus.busy, bus.done}); end
    // Idle with start low stays idle
    step();
    checks++; if ({bus.busy, bus.done, bus.PC_Addr} !== {2'b00, 32'd0}) begin errors++; $display("FAIL idle_hold actual=%b/%h required=00/0", {bus.busy, bus.done}, bus.PC_Addr); end
  endtask

  task automatic test_self_loop();
    logic [31:0] exp_pc;
    start_run();
    checks++; if ({bus.cpu_en, bus.busy, bus.done} !== 3'b110) begin errors++; $display("FAIL run_ctl actual=%b required=110", {bus.cpu_en, bus.busy, bus.done}); end
    for (int i = 0; i < 5; i++) begin
      exp_pc = 32'(4 * i);
      checks++; if (bus.PC_Addr !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d] actual=%h required=%h", i, bus.PC_Addr, exp_pc); end
      bus.Next_Addr = exp_pc + 32'd4;
      step();
    end
    checks++; if (bus.PC_Addr !== 32'd20) begin errors++; $display("FAIL seq_pc[5] actual=%h required=%h", bus.PC_Addr, 32'd20); end
    bus.Next_Addr = 32'd20;
    step();
    checks++; if ({bus.cpu_en, bus.busy, bus.done} !== 3'b001) begin errors++; $display("FAIL loop_ctl actual=%b required=001", {bus.cpu_en, bus.busy, bus.done}); end
    checks++; if (bus.halt_cause !== 2'b01) begin errors++; $display("FAIL loop_cause actual=%b required=01", bus.halt_cause); end
    checks++; if (bus.retired !== 32'd6) begin errors++; $display("FAIL loop_retired actual=%0d required=6", bus.retired); end
    checks++; if (bus.PC_Addr !== 32'd20) begin errors++; $display("FAIL loop_pc actual=%h required=%h", bus.PC_Addr, 32'd20); end
    // HALT holds everything
    bus.Next_Addr = 32'd100;
    step();
    checks++; if ({bus.done, bus.halt_cause, bus.retired, bus.PC_Addr} !== {1'b1, 2'b01, 32'd6, 32'd20}) begin errors++; $display("FAIL halt_hold actual=%b/%b/%0d/%h required=1/01/6/14", bus.done, bus.halt_cause, bus.retired, bus.PC_Addr); end
  endtask

  task automatic test_restart_misaligned();
    // start in HALT clears state and re-enters RUN
    start_run();
    checks++; if (bus.retired !== 32'd0) begin errors++; $display("FAIL restart_retired actual=%0d required=0", bus.retired); end
    checks++; if (bus.PC_Addr !== 32'd0) begin errors++; $display("FAIL restart_pc actual=%h required=0", bus.PC_Addr); end
    checks++; if ({bus.busy, bus.done, bus.halt_cause} !== 4'b1000) begin errors++; $display("FAIL restart_ctl actual=%b required=1000", {bus.busy, bus.done, bus.halt_cause}); end
    bus.Next_Addr = 32'h0000_0402;
    step();
    checks++; if ({bus.done, bus.halt_cause} !== 3'b110) begin errors++; $display("FAIL misalign_cause actual=%b required=110", {bus.done, bus.halt_cause}); end
    checks++; if (bus.PC_Addr !== 32'd0) begin errors++; $display("FAIL misalign_pc actual=%h required=0", bus.PC_Addr); end
    checks++; if (bus.retired !== 32'd1) begin errors++; $display("FAIL misalign_retired actual=%0d required=1", bus.retired); end
  endtask

  task automatic test_fault_range();
    start_run();
    bus.Next_Addr = 32'd4;
    step();
    bus.Next_Addr = 32'h0000_0400;
    step();
    checks++; if ({bus.done, bus.halt_cause} !== 3'b110) begin errors++; $display("FAIL range_cause actual=%b required=110", {bus.done, bus.halt_cause}); end
    checks++; if ({bus.PC_Addr, bus.retired} !== {32'd4, 32'd2}) begin errors++; $display("FAIL range_state actual=%h/%0d required=4/2", bus.PC_Addr, bus.retired); end
    // Last legal aligned address does not fault
    start_run();
    bus.Next_Addr = 32'h0000_03FC;
    step();
    checks++; if ({bus.busy, bus.PC_Addr} !== {1'b1, 32'h0000_03FC}) begin errors++; $display("FAIL range_edge actual=%b/%h required=1/3fc", bus.busy, bus.PC_Addr); end
    bus.Next_Addr = 32'hFFFF_FFFC;
    step();
    checks++; if ({bus.done, bus.halt_cause, bus.PC_Addr} !== {3'b110, 32'h0000_03FC}) begin errors++; $display("FAIL range_big actual=%b/%h required=110/3fc", {bus.done, bus.halt_cause}, bus.PC_Addr); end
  endtask

  task automatic test_watchdog();
    logic [31:0] exp_pc;
    start_run();
    for (int i = 0; i < 8; i++) begin
      exp_pc = 32'(4 * i);
      checks++; if ({bus.busy, bus.PC_Addr} !== {1'b1, exp_pc}) begin errors++; $display("FAIL wdog_step[%0d] actual=%b/%h required=1/%h", i, bus.busy, bus.PC_Addr, exp_pc); end
      bus.Next_Addr = exp_pc + 32'd4;
      step();
    end
    checks++; if ({bus.done, bus.halt_cause} !== 3'b111) begin errors++; $display("FAIL wdog_cause actual=%b required=111", {bus.done, bus.halt_cause}); end
    checks++; if ({bus.retired, bus.PC_Addr} !== {32'd8, 32'd28}) begin errors++; $display("FAIL wdog_state actual=%0d/%h required=8/1c", bus.retired, bus.PC_Addr); end
  endtask

  task automatic test_priority();
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    checks++; if (bus2.PC_Addr !== 32'h0000_0800) begin errors++; $display("FAIL prio_pc actual=%h required=800", bus2.PC_Addr); end
    bus2.Next_Addr = 32'h0000_0800;
    step();
    checks++; if ({bus2.done, bus2.halt_cause} !== 3'b101) begin errors++; $display("FAIL prio_cause actual=%b required=101", {bus2.done, bus2.halt_cause}); end
    // Same DUT, out of range but not a loop: fault
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    bus2.Next_Addr = 32'h0000_0804;
    step();
    checks++; if ({bus2.done, bus2.halt_cause} !== 3'b110) begin errors++; $display("FAIL prio_fault actual=%b required=110", {bus2.done, bus2.halt_cause}); end
  endtask

  task automatic test_reset_mid_run();
    start_run();
    bus.Next_Addr = 32'd4;
    step();
    bus.Next_Addr = 32'd8;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({bus.cpu_en, bus.busy, bus.done} !== 3'b000) begin errors++; $display("FAIL midrst_ctl actual=%b required=000", {bus.cpu_en, bus.busy, bus.done}); end
    checks++; if ({bus.PC_Addr, bus.retired} !== {32'd0, 32'd0}) begin errors++; $display("FAIL midrst_state actual=%h/%0d required=0/0", bus.PC_Addr, bus.retired); end
    rst = 1'b0;
    step();
    checks++; if ({bus.busy, bus.PC_Addr} !== {1'b0, 32'd0}) begin errors++; $display("FAIL midrst_idle actual=%b/%h required=0/0", bus.busy, bus.PC_Addr); end
  endtask

  task automatic test_start_in_run();
    start_run();
    bus.Next_Addr = 32'd4;
    step();
    bus.start = 1'b1;
    bus.Next_Addr = 32'd8;
    step();
    bus.start = 1'b0;
    checks++; if ({bus.busy, bus.PC_Addr, bus.retired} !== {1'b1, 32'd8, 32'd2}) begin errors++; $display("FAIL start_in_run actual=%b/%h/%0d required=1/8/2", bus.busy, bus.PC_Addr, bus.retired); end
    bus.Next_Addr = 32'd8;
    step();
    checks++; if ({bus.done, bus.halt_cause, bus.retired} !== {3'b101, 32'd3}) begin errors++; $display("FAIL start_in_run_halt actual=%b/%0d required=101/3", {bus.done, bus.halt_cause}, bus.retired); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_self_loop();
    test_restart_misaligned();
    test_fault_range();
    test_watchdog();
    test_priority();
    test_reset_mid_run();
    test_start_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
